qpu_exu_trigger: RTL and testbench
==================================

QPU_EXU_TRIGGER -- requirements
Module: qpu_exu_trigger

Interface
REQ-001 Parameters (name, default, meaning): TIME_W, 16, timeline width; EV_NUM, 4, event channels; EV_W, 8, per-channel event data width; BUF_DP, 2, per-channel output buffer depth.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  single-cycle pulse; begins run from IDLE.
REQ-005 stop  input  1  single-cycle pulse; aborts run and returns to IDLE.
REQ-006 err_clr  input  1  clears the error flag and leaves ERR.
REQ-007 tragger_o_clk_ena  input  1  count enable from the execution queue; 0 = hold timeline.
REQ-008 tragger_o_clk  output  TIME_W  current timeline value, registered.
REQ-009 evq_dest_o_valid  input  EV_NUM  per-channel event strobe.
REQ-010 evq_dest_o_data  input  EV_NUM*EV_W  channel i occupies bits [i*EV_W +: EV_W].
REQ-011 ch_valid  output  EV_NUM  per-channel buffered event available.
REQ-012 ch_ready  input  EV_NUM  per-channel downstream pop.
REQ-013 ch_data  output  EV_NUM*EV_W  head-entry data, same packing as REQ-010.
REQ-014 ch_stamp  output  EV_NUM*TIME_W  head-entry capture time.
REQ-015 state_o  output  2  FSM state: IDLE=0, RUN=1, DONE=2, ERR=3.
REQ-016 ovf_err  output  EV_NUM  sticky per-channel overflow flag.

Function
REQ-017 FSM IDLE -> RUN on start; RUN -> IDLE on stop; RUN -> DONE when the timeline reaches all-ones; RUN -> ERR on any overflow; DONE -> IDLE on stop; ERR -> IDLE on err_clr; stop has priority over every other transition.
REQ-018 In RUN, tragger_o_clk increments by 1 on each edge where tragger_o_clk_ena=1 and holds when it is 0; in all other states it holds.
REQ-019 The timeline saturates at 2^TIME_W-1 and never wraps; the increment to all-ones is the edge that also enters DONE.
REQ-020 Entering IDLE (from stop or err_clr) clears tragger_o_clk to 0 and flushes all channel buffers; ovf_err is cleared only by err_clr or rst.
REQ-021 Channel i pushes when in RUN and evq_dest_o_valid[i]=1, storing {data_i, tragger_o_clk current value}; events outside RUN are discarded without error.
REQ-022 Each channel is an independent BUF_DP-entry FIFO; ch_valid[i] = not empty, registered, first asserted the cycle after the push edge (latency 1).
REQ-023 Pop occurs when ch_valid[i] & ch_ready[i]; ch_data/ch_stamp present the oldest entry and advance on the pop edge.
REQ-024 Simultaneous push and pop on a full channel: both succeed, occupancy unchanged; on an empty channel: the push is stored and the pop is ignored (no bypass).
REQ-025 Push on a full channel with no pop: data dropped, ovf_err[i] set, FSM enters ERR on the same edge; buffers keep their contents and remain poppable in ERR.
REQ-026 Pointers wrap modulo BUF_DP; occupancy never exceeds BUF_DP or goes below 0.
REQ-027 ch_data and ch_stamp are all-zero whenever ch_valid[i]=0.

Reset
REQ-028 rst asserted at any time, including mid-run, forces within the same cycle: state_o=IDLE, tragger_o_clk=0, ch_valid=0, ch_data=0, ch_stamp=0, ovf_err=0, all pointers 0.
REQ-029 After rst deasserts, no transition occurs until the first start pulse.

Verification
REQ-030 rst, start, ena=1 for 5 cycles, then ena=0 for 3 -> tragger_o_clk reads 5 and holds 5 for 3 cycles.
REQ-031 RUN at time 7, valid=4'b0001, data0=0xA5, ch_ready=0 -> next cycle ch_valid[0]=1, ch_data[7:0]=0xA5, ch_stamp[15:0]=7.
REQ-032 Channel 2, 3 consecutive pushes, ch_ready=0 -> third push sets ovf_err[2]=1, state_o=3, two entries still poppable in order; err_clr -> state_o=0, ovf_err=0, buffers empty.
REQ-033 Channel 1 full, push with ch_ready[1]=1 same cycle -> no overflow, occupancy stays 2, new head is the former second entry.
REQ-034 Timeline preset near 0xFFFE (run 65534 enabled cycles), ena=1 -> reaches 0xFFFF, state_o=2, holds at 0xFFFF; stop -> IDLE, 0.
REQ-035 rst pulsed while channel 3 holds 2 entries at time 40 -> all outputs zero that cycle; start then valid on ch3 -> stamp 0.

Source files
------------

// File: rtl/qpu_exu_trigger.sv
// qpu_exu_trigger: run-controlled saturating timeline with per-channel time-stamped event FIFOs
//   clk, rst              clock, asynchronous active-high reset
//   start/stop/err_clr    run control pulses
//   tragger_o_clk_ena     timeline count enable; tragger_o_clk is the registered timeline
//   evq_dest_o_valid/data per-channel event strobes and packed event data
//   ch_valid/ready/data/stamp  per-channel FIFO head (data and capture time, zero when empty)
//   state_o               IDLE=0 RUN=1 DONE=2 ERR=3
//   ovf_err               sticky per-channel overflow flags
module qpu_exu_trigger #(
   parameter int TIME_W = 16,
   parameter int EV_NUM = 4,
   parameter int EV_W   = 8,
   parameter int BUF_DP = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     err_clr,
   input  logic                     tragger_o_clk_ena,
   output logic [TIME_W-1:0]        tragger_o_clk,
   input  logic [EV_NUM-1:0]        evq_dest_o_valid,
   input  logic [EV_NUM*EV_W-1:0]   evq_dest_o_data,
   output logic [EV_NUM-1:0]        ch_valid,
   input  logic [EV_NUM-1:0]        ch_ready,
   output logic [EV_NUM*EV_W-1:0]   ch_data,
   output logic [EV_NUM*TIME_W-1:0] ch_stamp,
   output logic [1:0]               state_o,
   output logic [EV_NUM-1:0]        ovf_err
);
   localparam int PW = BUF_DP > 1 ? $clog2(BUF_DP) : 1;
   localparam int CW = $clog2(BUF_DP + 1);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;
   state_t            state_q;
   logic [TIME_W-1:0] time_q, time_d;
   logic [EV_NUM-1:0] ovf, ovf_q;
   logic              flush;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(BUF_DP - 1) ? '0 : p + 1'b1;
   endfunction
   // Every return to IDLE clears the timeline and empties all channels.
   always_comb begin
      flush  = (stop && state_q != IDLE) || (err_clr && state_q == ERR);
      time_d = (state_q == RUN && tragger_o_clk_ena && time_q != '1) ? time_q + 1'b1 : time_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         time_q  <= '0;
         ovf_q   <= '0;
      end else begin
         ovf_q  <= err_clr ? '0 : ovf_q | ovf;
         time_q <= flush ? '0 : time_d;
         if (flush) state_q <= IDLE;
         else if (state_q == IDLE && start) state_q <= RUN;
         else if (state_q == RUN && |ovf) state_q <= ERR;
         // the timeline is never all-ones inside RUN, so reaching it here means this edge saturated it
         else if (state_q == RUN && &time_d) state_q <= DONE;
      end
   assign tragger_o_clk = time_q;
   assign state_o       = state_q;
   assign ovf_err       = ovf_q;
   for (genvar i = 0; i < EV_NUM; i++) begin : g_ch
      logic [EV_W-1:0]   dat_q [BUF_DP];
      logic [TIME_W-1:0] stp_q [BUF_DP];
      logic [PW-1:0]     rd_q, wr_q;
      logic [CW-1:0]     cnt_q, cnt_d;
      logic              vld_q, push, pop, wr;
      assign push   = state_q == RUN && evq_dest_o_valid[i];
      assign pop    = vld_q && ch_ready[i];
      // a pop on a full channel frees the slot the same edge, so the push still lands
      assign wr     = push && (cnt_q != CW'(BUF_DP) || pop);
      assign ovf[i] = push && !wr;
      assign cnt_d  = cnt_q + CW'(wr) - CW'(pop);
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
         end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
         end else begin
            if (wr) wr_q <= nxt(wr_q);
            if (pop) rd_q <= nxt(rd_q);
            cnt_q <= cnt_d;
            vld_q <= cnt_d != '0;
         end
      always_ff @(posedge clk)
         if (wr) begin
            dat_q[wr_q] <= evq_dest_o_data[i*EV_W +: EV_W];
            stp_q[wr_q] <= time_q;
         end
      assign ch_valid[i]                 = vld_q;
      assign ch_data[i*EV_W +: EV_W]     = vld_q ? dat_q[rd_q] : '0;
      assign ch_stamp[i*TIME_W +: TIME_W] = vld_q ? stp_q[rd_q] : '0;
   end
endmodule

// File: tb/tb_qpu_exu_trigger.sv
// tb_qpu_exu_trigger: scoreboard bench with a queue-based reference model of qpu_exu_trigger
module tb_qpu_exu_trigger;
   localparam int DP = 2;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, err_clr = 1'b0, ena = 1'b0;
   logic [15:0] tclk;
   logic [3:0]  ev_valid = '0, ch_ready = '0, ch_valid, ovf_err;
   logic [31:0] ev_data = '0, ch_data;
   logic [63:0] ch_stamp;
   logic [1:0]  state_o;
   int          mstate = 0;
   logic [15:0] mtime = '0;
   logic [3:0]  movf = '0;
   int          occ [4] = '{default: 0};
   logic [23:0] sb [4][$];
   int          pass_n = 0, chk_n = 0;

   qpu_exu_trigger #(.TIME_W(16), .EV_NUM(4), .EV_W(8), .BUF_DP(DP)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .err_clr(err_clr),
      .tragger_o_clk_ena(ena), .tragger_o_clk(tclk),
      .evq_dest_o_valid(ev_valid), .evq_dest_o_data(ev_data),
      .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data), .ch_stamp(ch_stamp),
      .state_o(state_o), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      chk_n++;
      if (a === e) pass_n++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, e, $time);
   endtask

   task automatic reset_model();
      mstate = 0;
      mtime  = '0;
      movf   = '0;
      for (int i = 0; i < 4; i++) begin
         occ[i] = 0;
         sb[i].delete();
      end
   endtask

   // Reference behaviour for one rising edge, from the inputs held during the cycle.
   task automatic model_edge();
      logic [3:0] pop;
      logic       any_ovf;
      if (rst) begin
         reset_model();
         return;
      end
      any_ovf = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pop[i] = occ[i] > 0 && ch_ready[i];
         if (mstate == 1 && ev_valid[i]) begin
            if (occ[i] == DP && !pop[i]) begin
               movf[i] = 1'b1;
               any_ovf = 1'b1;
            end else begin
               sb[i].push_back({ev_data[i*8 +: 8], mtime});
               occ[i]++;
            end
         end
         if (pop[i]) occ[i]--;
      end
      if (err_clr) movf = '0;
      if ((stop && mstate != 0) || (err_clr && mstate == 3)) begin
         mstate = 0;
         mtime  = '0;
         for (int i = 0; i < 4; i++) begin
            occ[i] = 0;
            sb[i].delete();
         end
      end else if (mstate == 0 && start) mstate = 1;
      else if (mstate == 1) begin
         if (ena && mtime != 16'hFFFF) mtime++;
         if (any_ovf) mstate = 3;
         else if (mtime == 16'hFFFF) mstate = 2;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      start    = 1'b0;
      stop     = 1'b0;
      err_clr  = 1'b0;
      ev_valid = '0;
   endtask

   // Monitor: compares DUT against the model and pops the scoreboard on every presented pop.
   always @(negedge clk) begin
      logic [23:0] e;
      chk("state", 64'(state_o), 64'(mstate));
      chk("timeline", 64'(tclk), 64'(mtime));
      chk("ovf_err", 64'(ovf_err), 64'(movf));
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ch_valid%0d", i), 64'(ch_valid[i]), 64'(sb[i].size() != 0));
         if (ch_valid[i] && ch_ready[i]) begin
            if (sb[i].size() == 0) begin
               chk_n++;
               $display("FAIL pop%0d: got a pop with no expected entry at %0t", i, $time);
            end else begin
               e = sb[i].pop_front();
               chk($sformatf("ch_data%0d", i), 64'(ch_data[i*8 +: 8]), 64'(e[23:16]));
               chk($sformatf("ch_stamp%0d", i), 64'(ch_stamp[i*16 +: 16]), 64'(e[15:0]));
            end
         end else if (!ch_valid[i])
            chk($sformatf("empty_zero%0d", i), 64'({ch_data[i*8 +: 8], ch_stamp[i*16 +: 16]}), 64'(0));
      end
   end

   initial begin
      step();
      step();
      rst = 1'b0;
      step();
      step();
      // timeline counts while enabled and holds otherwise
      start = 1'b1;
      step();
      ena = 1'b1;
      repeat (5) step();
      ena = 1'b0;
      chk("time_after_5", 64'(tclk), 64'(5));
      repeat (3) step();
      chk("time_hold", 64'(tclk), 64'(5));
      // single push captures the current timeline
      ena = 1'b1;
      repeat (2) step();
      ena = 1'b0;
      ev_valid = 4'b0001;
      ev_data  = 32'h0000_00A5;
      step();
      chk("push_valid", 64'(ch_valid[0]), 64'(1));
      chk("push_data", 64'(ch_data[7:0]), 64'(8'hA5));
      chk("push_stamp", 64'(ch_stamp[15:0]), 64'(7));
      ch_ready = 4'b0001;
      step();
      ch_ready = '0;
      stop = 1'b1;
      step();
      // randomized traffic, with run control issued only where it is meaningful
      for (int n = 0; n < 600; n++) begin
         start    = mstate == 0 && $urandom_range(3) == 0;
         stop     = (mstate == 1 || mstate == 2) && $urandom_range(39) == 0;
         err_clr  = mstate == 3 && $urandom_range(4) == 0;
         ena      = $urandom_range(3) != 0;
         ev_valid = stop ? 4'b0 : 4'($urandom & $urandom);
         ev_data  = $urandom;
         ch_ready = 4'($urandom);
         step();
      end
      ev_valid = '0;
      ch_ready = '0;
      ena      = 1'b0;
      if (mstate == 3) err_clr = 1'b1;
      else if (mstate != 0) stop = 1'b1;
      step();
      // overflow on channel 2, drain in ERR, then clear
      start = 1'b1;
      step();
      for (int k = 1; k <= 3; k++) begin
         ev_valid = 4'b0100;
         ev_data  = 32'(k * 8'h11) << 16;
         step();
      end
      chk("ovf_ch2", 64'(ovf_err), 64'(4'b0100));
      chk("ovf_state", 64'(state_o), 64'(3));
      ch_ready = 4'b0100;
      repeat (2) step();
      ch_ready = '0;
      err_clr = 1'b1;
      step();
      chk("clr_state", 64'(state_o), 64'(0));
      chk("clr_ovf", 64'(ovf_err), 64'(0));
      chk("clr_valid", 64'(ch_valid), 64'(0));
      // simultaneous push and pop on a full channel 1
      start = 1'b1;
      step();
      ev_valid = 4'b0010;
      ev_data  = 32'h0000_4100;
      step();
      ev_valid = 4'b0010;
      ev_data  = 32'h0000_4200;
      step();
      ev_valid = 4'b0010;
      ev_data  = 32'h0000_4300;
      ch_ready = 4'b0010;
      step();
      ch_ready = '0;
      chk("full_pp_ovf", 64'(ovf_err), 64'(0));
      chk("full_pp_state", 64'(state_o), 64'(1));
      chk("full_pp_head", 64'(ch_data[15:8]), 64'(8'h42));
      ch_ready = 4'b0010;
      repeat (2) step();
      ch_ready = '0;
      stop = 1'b1;
      step();
      // asynchronous reset while channel 3 holds two entries
      start = 1'b1;
      step();
      ena = 1'b1;
      while (mtime != 16'd38) step();
      ev_valid = 4'b1000;
      ev_data  = 32'h5100_0000;
      step();
      ev_valid = 4'b1000;
      ev_data  = 32'h5200_0000;
      step();
      ena = 1'b0;
      chk("pre_rst_time", 64'(tclk), 64'(40));
      chk("pre_rst_valid", 64'(ch_valid), 64'(4'b1000));
      rst = 1'b1;
      #1;
      chk("rst_state", 64'(state_o), 64'(0));
      chk("rst_time", 64'(tclk), 64'(0));
      chk("rst_valid", 64'(ch_valid), 64'(0));
      chk("rst_data", 64'(ch_data), 64'(0));
      chk("rst_stamp", ch_stamp, 64'(0));
      chk("rst_ovf", 64'(ovf_err), 64'(0));
      reset_model();
      step();
      rst = 1'b0;
      step();
      start = 1'b1;
      step();
      ev_valid = 4'b1000;
      ev_data  = 32'h5A00_0000;
      ena      = 1'b1;
      step();
      chk("post_rst_valid", 64'(ch_valid[3]), 64'(1));
      chk("post_rst_data", 64'(ch_data[31:24]), 64'(8'h5A));
      chk("post_rst_stamp", 64'(ch_stamp[63:48]), 64'(0));
      ena = 1'b0;
      stop = 1'b1;
      step();
      // saturation of the timeline ends the run
      start = 1'b1;
      step();
      ena = 1'b1;
      while (mtime != 16'hFFFE) step();
      chk("near_max_state", 64'(state_o), 64'(1));
      step();
      chk("sat_time", 64'(tclk), 64'(16'hFFFF));
      chk("sat_state", 64'(state_o), 64'(2));
      step();
      chk("sat_hold", 64'(tclk), 64'(16'hFFFF));
      ena = 1'b0;
      stop = 1'b1;
      step();
      chk("done_stop_state", 64'(state_o), 64'(0));
      chk("done_stop_time", 64'(tclk), 64'(0));
      $display("%0d/%0d checks passed", pass_n, chk_n);
      $finish;
   end
endmodule
